// File: rtl/bnn_pkg.sv
// Shared constants for the 8-8-4 BNN scheduler: sizes, threshold, default weights, FSM encoding.
// Latency: n/a (package).
// Backpressure: n/a (package).
package bnn_pkg;

    localparam int N_IN   = 8;
    localparam int N_L1   = 8;
    localparam int N_L2   = 4;
    localparam int N_W    = N_L1 + N_L2;
    localparam int THRESH = 6;

    // Word i sits at bits [8*i +: 8], so w0 is the rightmost byte.
    localparam logic [N_W*N_IN-1:0] W_DEFAULT = {
        8'h0F, 8'hF7, 8'h62, 8'hF9,
        8'h3A, 8'h67, 8'hB7, 8'hED, 8'h18, 8'h7A, 8'h41, 8'hA0
    };

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_L1   = 2'd1;
    localparam logic [1:0] ST_L2   = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    function automatic logic [N_IN-1:0] default_weight(input int i);
        return W_DEFAULT[i*N_IN +: N_IN];
    endfunction

endpackage

// File: rtl/bnn_xnor_popcount.sv
// Shared neuron datapath: popcount of x XNOR w, fires when the count reaches THRESH.
// Latency: combinational.
// Backpressure: none.
module bnn_xnor_popcount
    import bnn_pkg::*;
(
    input  logic [N_IN-1:0] x,
    input  logic [N_IN-1:0] w,
    output logic [3:0]      sum,
    output logic            fire
);

    always_comb begin
        sum = '0;
        for (int i = 0; i < N_IN; i++) begin
            sum = sum + {3'b000, ~(x[i] ^ w[i])};
        end
    end

    assign fire = (sum >= 4'(THRESH));

endmodule

// File: rtl/bnn_infer_sched.sv
// Inference scheduler stepping one XNOR-popcount unit over 8 L1 then 4 L2 neurons; BNN_SUM_DEBUG_EN adds dbg ports.
// Latency: start accepted at E0, done pulses 13 cycles later with both activation vectors.
// Backpressure: start and weight writes are only taken in IDLE; busy-time starts drop, busy-time writes flag wr_err.
module bnn_infer_sched
    import bnn_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] in_vec,
    output logic       busy,
    output logic       done,
    output logic [7:0] out_l1,
    output logic [3:0] out_l2,
    input  logic       wr_en,
    input  logic [3:0] wr_addr,
    input  logic [7:0] wr_data,
    output logic       wr_err
`ifdef BNN_SUM_DEBUG_EN
    ,
    output logic [3:0] dbg_sum,
    output logic [3:0] dbg_idx
`endif
);

    logic [1:0]      state;
    logic [2:0]      idx;
    logic [N_IN-1:0] in_cap;
    logic [N_L1-1:0] act;
    logic [N_L2-1:0] act2;
    logic [N_IN-1:0] wts [N_W];

    logic [N_IN-1:0] act_rev;
    logic [N_IN-1:0] op_x;
    logic [3:0]      w_sel;
    logic [3:0]      sum;
    logic            fire;
    logic            wr_ok;

    // Layer 2 consumes the layer-1 vector bit-reversed.
    always_comb begin
        act_rev = '0;
        for (int b = 0; b < N_IN; b++) begin
            act_rev[b] = act[N_IN-1-b];
        end
    end

    assign op_x  = (state == ST_L2) ? act_rev : in_cap;
    assign w_sel = (state == ST_L2) ? {2'b10, idx[1:0]} : {1'b0, idx};
    assign wr_ok = wr_en && (state == ST_IDLE) && (wr_addr <= 4'd11);
    assign busy  = (state != ST_IDLE);

    bnn_xnor_popcount u_pop (
        .x    (op_x),
        .w    (wts[w_sel]),
        .sum  (sum),
        .fire (fire)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= ST_IDLE;
            idx    <= '0;
            in_cap <= '0;
            act    <= '0;
            act2   <= '0;
            done   <= 1'b0;
            wr_err <= 1'b0;
            out_l1 <= '0;
            out_l2 <= '0;
            for (int i = 0; i < N_W; i++) begin
                wts[i] <= default_weight(i);
            end
        end else begin
            done   <= 1'b0;
            wr_err <= wr_en && !wr_ok;
            if (wr_ok) begin
                wts[wr_addr] <= wr_data;
            end
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        in_cap <= in_vec;
                        idx    <= '0;
                        state  <= ST_L1;
                    end
                end
                ST_L1: begin
                    act[idx] <= fire;
                    idx      <= idx + 3'd1;
                    if (idx == 3'd7) begin
                        idx   <= '0;
                        state <= ST_L2;
                    end
                end
                ST_L2: begin
                    act2[idx[1:0]] <= fire;
                    idx            <= idx + 3'd1;
                    if (idx[1:0] == 2'd3) begin
                        idx   <= '0;
                        state <= ST_DONE;
                    end
                end
                default: begin
                    out_l1 <= act;
                    out_l2 <= act2;
                    done   <= 1'b1;
                    state  <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef BNN_SUM_DEBUG_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            dbg_sum <= '0;
            dbg_idx <= '0;
        end else if (state == ST_L1 || state == ST_L2) begin
            dbg_sum <= sum;
            dbg_idx <= w_sel;
        end
    end
`else
    logic unused_sum;
    assign unused_sum = ^sum;
`endif

endmodule

// File: tb/tb_bnn_infer_sched.sv
// Directed bench for bnn_infer_sched with hand-computed activation vectors.
// Latency: n/a. Backpressure: n/a.
module tb_bnn_infer_sched;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic [7:0] in_vec = '0;
    logic       busy;
    logic       done;
    logic [7:0] out_l1;
    logic [3:0] out_l2;
    logic       wr_en = 1'b0;
    logic [3:0] wr_addr = '0;
    logic [7:0] wr_data = '0;
    logic       wr_err;

    int checks = 0;
    int errors = 0;
    int lat;
    int werrs;
    int ndone;

    bnn_infer_sched dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .in_vec  (in_vec),
        .busy    (busy),
        .done    (done),
        .out_l1  (out_l1),
        .out_l2  (out_l2),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .wr_err  (wr_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic start_run(input logic [7:0] v);
        in_vec = v;
        start  = 1'b1;
        tick();
        start  = 1'b0;
    endtask

    // Returns cycles until done (0 if it never came) and wr_err pulses seen meanwhile.
    task automatic wait_done(output int cyc, output int errs);
        cyc  = 0;
        errs = 0;
        for (int k = 1; k <= 40; k++) begin
            tick();
            if (wr_err) errs++;
            if (done) begin
                cyc = k;
                break;
            end
        end
    endtask

    task automatic count_done(input int n, output int cnt);
        cnt = 0;
        for (int k = 0; k < n; k++) begin
            tick();
            if (done) cnt++;
        end
    endtask

    initial begin
        // 1: reset state, then in_vec=FF
        do_reset();
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_done", 32'(done), 32'h0);
        chk("rst_wr_err", 32'(wr_err), 32'h0);
        chk("rst_out_l1", 32'(out_l1), 32'h00);
        chk("rst_out_l2", 32'(out_l2), 32'h0);
        start_run(8'hFF);
        chk("t1_busy_run", 32'(busy), 32'h1);
        wait_done(lat, werrs);
        chk("t1_latency", 32'(lat), 32'd13);
        chk("t1_out_l1", 32'(out_l1), 32'h30);
        chk("t1_out_l2", 32'(out_l2), 32'h8);
        tick();
        chk("t1_busy_after", 32'(busy), 32'h0);
        chk("t1_done_pulse", 32'(done), 32'h0);

        // 2: in_vec=00 with default weights
        do_reset();
        start_run(8'h00);
        wait_done(lat, werrs);
        chk("t2_latency", 32'(lat), 32'd13);
        chk("t2_out_l1", 32'(out_l1), 32'h0B);
        chk("t2_out_l2", 32'(out_l2), 32'h0);

        // 3: w11=D0 written in the same cycle start is accepted
        in_vec  = 8'h00;
        start   = 1'b1;
        wr_en   = 1'b1;
        wr_addr = 4'd11;
        wr_data = 8'hD0;
        tick();
        start = 1'b0;
        wr_en = 1'b0;
        chk("t3_wr_err_now", 32'(wr_err), 32'h0);
        wait_done(lat, werrs);
        chk("t3_latency", 32'(lat), 32'd13);
        chk("t3_wr_err_cnt", 32'(werrs), 32'd0);
        chk("t3_out_l1", 32'(out_l1), 32'h0B);
        chk("t3_out_l2", 32'(out_l2), 32'h8);

        // 4: write during L1 is dropped; out-of-range write in IDLE flagged
        start_run(8'hFF);
        tick();
        tick();
        wr_en   = 1'b1;
        wr_addr = 4'd0;
        wr_data = 8'hFF;
        tick();
        wr_en = 1'b0;
        chk("t4_busy_wr_err", 32'(wr_err), 32'h1);
        tick();
        chk("t4_busy_wr_err_end", 32'(wr_err), 32'h0);
        wait_done(lat, werrs);
        chk("t4_latency", 32'(lat), 32'd9);
        chk("t4_out_l1", 32'(out_l1), 32'h30);
        chk("t4_out_l2_w11", 32'(out_l2), 32'h0);
        tick();
        wr_en   = 1'b1;
        wr_addr = 4'd12;
        wr_data = 8'h55;
        tick();
        wr_en = 1'b0;
        chk("t4_addr12_wr_err", 32'(wr_err), 32'h1);
        tick();
        chk("t4_addr12_wr_err_end", 32'(wr_err), 32'h0);

        // 5: second start at E3 ignored; outputs hold after done
        start_run(8'h00);
        tick();
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(lat, werrs);
        chk("t5_latency", 32'(lat), 32'd10);
        count_done(20, ndone);
        chk("t5_extra_done", 32'(ndone), 32'd0);
        chk("t5_busy_idle", 32'(busy), 32'h0);
        chk("t5_hold_l1", 32'(out_l1), 32'h0B);
        chk("t5_hold_l2", 32'(out_l2), 32'h8);

        // 6: reset at E5 aborts, clears outputs, restores default weights
        start_run(8'hFF);
        for (int k = 0; k < 4; k++) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("t6_busy", 32'(busy), 32'h0);
        chk("t6_out_l1", 32'(out_l1), 32'h00);
        chk("t6_out_l2", 32'(out_l2), 32'h0);
        count_done(20, ndone);
        chk("t6_no_done", 32'(ndone), 32'd0);
        start_run(8'hFF);
        wait_done(lat, werrs);
        chk("t6_latency", 32'(lat), 32'd13);
        chk("t6_out_l1_rerun", 32'(out_l1), 32'h30);
        chk("t6_out_l2_rerun", 32'(out_l2), 32'h8);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
